// File: rtl/temporal_window_sequencer.sv
// temporal_window_sequencer: tags spatial HVs with command mode/label,
// counts window samples and closes train windows with a separator beat.
module temporal_window_sequencer #(
  parameter int unsigned MODE_WIDTH   = 2,
  parameter int unsigned LABEL_WIDTH  = 5,
  parameter int unsigned HV_DIMENSION = 2000,
  parameter int unsigned LEN_WIDTH    = 8
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RBI,
  input  logic                    CmdValid_SI,
  output logic                    CmdReady_SO,
  input  logic [MODE_WIDTH-1:0]   CmdMode_SI,
  input  logic [LABEL_WIDTH-1:0]  CmdLabel_DI,
  input  logic [LEN_WIDTH-1:0]    CmdLength_DI,
  input  logic                    CmdAbort_SI,
  input  logic                    ValidIn_SI,
  output logic                    ReadyOut_SO,
  input  logic [HV_DIMENSION-1:0] HypervectorIn_DI,
  output logic                    ValidOut_SO,
  input  logic                    ReadyIn_SI,
  output logic [MODE_WIDTH-1:0]   ModeOut_SO,
  output logic [LABEL_WIDTH-1:0]  LabelOut_DO,
  output logic [HV_DIMENSION-1:0] HypervectorOut_DO,
  output logic                    Busy_SO,
  output logic                    Done_SO,
  output logic [LEN_WIDTH-1:0]    SampleCount_DO
);

  localparam logic [MODE_WIDTH-1:0] MODE_PREDICT = MODE_WIDTH'(0);
  localparam logic [MODE_WIDTH-1:0] MODE_TRAIN   = MODE_WIDTH'(1);
  localparam logic [MODE_WIDTH-1:0] MODE_UPDATE  = MODE_WIDTH'(2);
  localparam logic [LABEL_WIDTH-1:0] SEP_LABEL   = '1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    SEPARATOR
  } state_e;

  state_e                  state_q, state_d;
  logic [MODE_WIDTH-1:0]   mode_q, mode_d;
  logic [LABEL_WIDTH-1:0]  label_q, label_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    valid_q, valid_d;
  logic [MODE_WIDTH-1:0]   out_mode_q, out_mode_d;
  logic [LABEL_WIDTH-1:0]  out_label_q, out_label_d;
  logic [HV_DIMENSION-1:0] out_hv_q, out_hv_d;

  logic                    free;
  logic                    cmd_acc;
  logic                    smp_acc;
  logic                    cmd_train;
  logic                    cur_train;
  logic [LEN_WIDTH-1:0]    cnt_inc;
  logic                    load;
  logic [LABEL_WIDTH-1:0]  ld_label;
  logic [HV_DIMENSION-1:0] ld_hv;

  assign free        = ~valid_q | ReadyIn_SI;
  assign CmdReady_SO = (state_q == IDLE);
  assign ReadyOut_SO = (state_q == STREAM) & free & ~CmdAbort_SI;
  assign cmd_acc     = CmdValid_SI & CmdReady_SO;
  assign smp_acc     = ValidIn_SI & ReadyOut_SO;
  assign cmd_train   = (CmdMode_SI == MODE_TRAIN) | (CmdMode_SI == MODE_UPDATE);
  assign cur_train   = (mode_q == MODE_TRAIN) | (mode_q == MODE_UPDATE);
  assign cnt_inc     = cnt_q + LEN_WIDTH'(1);

  // Command sequencing: window bookkeeping and which beat to load.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    label_d  = label_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    load     = 1'b0;
    ld_label = label_q;
    ld_hv    = HypervectorIn_DI;
    unique case (state_q)
      IDLE: begin
        if (cmd_acc) begin
          mode_d  = CmdMode_SI;
          label_d = CmdLabel_DI;
          len_d   = CmdLength_DI;
          cnt_d   = '0;
          if (CmdLength_DI != '0) begin
            state_d = STREAM;
          end else if (cmd_train) begin
            state_d = SEPARATOR;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (CmdAbort_SI) begin
          state_d = cur_train ? SEPARATOR : IDLE;
          done_d  = ~cur_train;
        end else if (smp_acc) begin
          load  = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = cur_train ? SEPARATOR : IDLE;
            done_d  = ~cur_train;
          end
        end
      end
      SEPARATOR: begin
        if (free) begin
          load     = 1'b1;
          ld_label = SEP_LABEL;
          ld_hv    = '0;
          state_d  = IDLE;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: load wins over a draining handshake.
  always_comb begin
    out_mode_d  = out_mode_q;
    out_label_d = out_label_q;
    out_hv_d    = out_hv_q;
    valid_d     = valid_q;
    if (load) begin
      out_mode_d  = mode_q;
      out_label_d = ld_label;
      out_hv_d    = ld_hv;
      valid_d     = 1'b1;
    end else if (ReadyIn_SI) begin
      valid_d = 1'b0;
    end
  end

  // State and output flops with synchronous active-low reset.
  always_ff @(posedge Clk_CI) begin
    if (!Reset_RBI) begin
      state_q     <= IDLE;
      mode_q      <= MODE_PREDICT;
      label_q     <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      out_mode_q  <= MODE_PREDICT;
      out_label_q <= '0;
      out_hv_q    <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      label_q     <= label_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      out_mode_q  <= out_mode_d;
      out_label_q <= out_label_d;
      out_hv_q    <= out_hv_d;
    end
  end

  assign ValidOut_SO       = valid_q;
  assign ModeOut_SO        = out_mode_q;
  assign LabelOut_DO       = out_label_q;
  assign HypervectorOut_DO = out_hv_q;
  assign Busy_SO           = (state_q != IDLE);
  assign Done_SO           = done_q;
  assign SampleCount_DO    = cnt_q;

endmodule

// File: tb/tb_temporal_window_sequencer.sv
// tb_temporal_window_sequencer: table vectors, corner sequences
// and a transaction-level reference model under random traffic.
module tb_temporal_window_sequencer;

  localparam int HVW = 2000;
  localparam logic [4:0] SEP = 5'd31;

  logic            Clk_CI = 1'b0;
  logic            Reset_RBI;
  logic            CmdValid_SI;
  logic            CmdReady_SO;
  logic [1:0]      CmdMode_SI;
  logic [4:0]      CmdLabel_DI;
  logic [7:0]      CmdLength_DI;
  logic            CmdAbort_SI;
  logic            ValidIn_SI;
  logic            ReadyOut_SO;
  logic [HVW-1:0]  HypervectorIn_DI;
  logic            ValidOut_SO;
  logic            ReadyIn_SI;
  logic [1:0]      ModeOut_SO;
  logic [4:0]      LabelOut_DO;
  logic [HVW-1:0]  HypervectorOut_DO;
  logic            Busy_SO;
  logic            Done_SO;
  logic [7:0]      SampleCount_DO;

  temporal_window_sequencer dut (
    .Clk_CI(Clk_CI), .Reset_RBI(Reset_RBI),
    .CmdValid_SI(CmdValid_SI), .CmdReady_SO(CmdReady_SO),
    .CmdMode_SI(CmdMode_SI), .CmdLabel_DI(CmdLabel_DI),
    .CmdLength_DI(CmdLength_DI), .CmdAbort_SI(CmdAbort_SI),
    .ValidIn_SI(ValidIn_SI), .ReadyOut_SO(ReadyOut_SO),
    .HypervectorIn_DI(HypervectorIn_DI),
    .ValidOut_SO(ValidOut_SO), .ReadyIn_SI(ReadyIn_SI),
    .ModeOut_SO(ModeOut_SO), .LabelOut_DO(LabelOut_DO),
    .HypervectorOut_DO(HypervectorOut_DO),
    .Busy_SO(Busy_SO), .Done_SO(Done_SO),
    .SampleCount_DO(SampleCount_DO)
  );

  always #5 Clk_CI = ~Clk_CI;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [HVW-1:0] rand_hv();
    logic [HVW-1:0] v;
    for (int i = 0; i < HVW / 16; i++) v[i*16 +: 16] = 16'($urandom);
    return v;
  endfunction

  typedef struct {
    logic [1:0]     m;
    logic [4:0]     l;
    logic [HVW-1:0] hv;
  } beat_t;

  typedef struct {
    logic [1:0] m;
    logic [4:0] l;
    logic [7:0] n;
    int stall_at;
    int stall_len;
    int abort_at;
    int exp_n;
    int exp_sep;
    int exp_done;
    int exp_first;
  } vec_t;

  beat_t          obs_q[$];
  logic [HVW-1:0] acc_q[$];
  int done_at, done_cnt, first_at, rdy_bad, unstable;
  bit cmd_ok;

  task automatic drive_cmd(input vec_t v);
    bit prev_stall;
    beat_t prev;
    obs_q.delete();
    acc_q.delete();
    done_at = -1; done_cnt = 0; first_at = -1;
    rdy_bad = 0; unstable = 0; prev_stall = 0;
    @(negedge Clk_CI);
    CmdValid_SI = 1; CmdMode_SI = v.m;
    CmdLabel_DI = v.l; CmdLength_DI = v.n;
    ValidIn_SI = 0; ReadyIn_SI = 1; CmdAbort_SI = 0;
    #2 cmd_ok = CmdReady_SO;
    for (int k = 1; k <= 14; k++) begin
      @(negedge Clk_CI);
      CmdValid_SI = 0;
      ReadyIn_SI = !(k >= v.stall_at && k < v.stall_at + v.stall_len);
      CmdAbort_SI = (k == v.abort_at);
      ValidIn_SI = 1;
      HypervectorIn_DI = rand_hv();
      #2;
      if (ValidOut_SO && first_at < 0) first_at = k;
      if (Done_SO) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (prev_stall && (ModeOut_SO != prev.m || LabelOut_DO != prev.l ||
                         HypervectorOut_DO != prev.hv)) unstable++;
      if (ValidOut_SO && !ReadyIn_SI && ReadyOut_SO) rdy_bad++;
      if (ValidOut_SO && ReadyIn_SI)
        obs_q.push_back('{ModeOut_SO, LabelOut_DO, HypervectorOut_DO});
      if (ValidIn_SI && ReadyOut_SO) acc_q.push_back(HypervectorIn_DI);
      prev_stall = ValidOut_SO && !ReadyIn_SI;
      prev = '{ModeOut_SO, LabelOut_DO, HypervectorOut_DO};
    end
    ValidIn_SI = 0; CmdAbort_SI = 0; ReadyIn_SI = 1;
  endtask

  task automatic check_vec(input vec_t v);
    chk("cmd_accepted", cmd_ok, 1);
    chk("samples_in", acc_q.size(), v.exp_n);
    chk("beats_out", obs_q.size(), v.exp_n + v.exp_sep);
    for (int i = 0; i < v.exp_n && i < obs_q.size(); i++) begin
      chk("beat_mode", obs_q[i].m, v.m);
      chk("beat_label", obs_q[i].l, v.l);
      if (i < acc_q.size()) chk("beat_hv", obs_q[i].hv == acc_q[i], 1);
    end
    if (v.exp_sep != 0 && obs_q.size() == v.exp_n + 1) begin
      chk("sep_label", obs_q[v.exp_n].l, SEP);
      chk("sep_mode", obs_q[v.exp_n].m, v.m);
      chk("sep_hv_zero", obs_q[v.exp_n].hv == '0, 1);
    end
    chk("done_cycle", done_at, v.exp_done);
    chk("done_pulses", done_cnt, 1);
    chk("first_out_cycle", first_at, v.exp_first);
    chk("ready_in_stall", rdy_bad, 0);
    chk("stable_in_stall", unstable, 0);
    chk("sample_count", SampleCount_DO, v.exp_n);
    chk("idle_after", Busy_SO, 0);
  endtask

  vec_t tbl[10];

  initial begin
    logic [HVW-1:0] hb;
    int n;
    // mode label len stall_at stall_len abort_at | n sep done first
    tbl[0] = '{2'd1, 5'd3,  8'd4,  0, 0, 0, 4, 1, 6, 2};
    tbl[1] = '{2'd0, 5'd7,  8'd3,  0, 0, 0, 3, 0, 4, 2};
    tbl[2] = '{2'd1, 5'd4,  8'd2,  2, 5, 0, 2, 1, 9, 2};
    tbl[3] = '{2'd1, 5'd10, 8'd10, 0, 0, 4, 3, 1, 6, 2};
    tbl[4] = '{2'd0, 5'd11, 8'd10, 0, 0, 4, 3, 0, 5, 2};
    tbl[5] = '{2'd1, 5'd9,  8'd0,  0, 0, 0, 0, 1, 2, 2};
    tbl[6] = '{2'd0, 5'd12, 8'd0,  0, 0, 0, 0, 0, 1, -1};
    tbl[7] = '{2'd3, 5'd1,  8'd2,  0, 0, 0, 2, 0, 3, 2};
    tbl[8] = '{2'd2, 5'd30, 8'd1,  0, 0, 0, 1, 1, 3, 2};
    tbl[9] = '{2'd1, 5'd5,  8'd3,  0, 0, 3, 2, 1, 5, 2};

    Reset_RBI = 0; CmdValid_SI = 0; CmdMode_SI = 0; CmdLabel_DI = 0;
    CmdLength_DI = 0; CmdAbort_SI = 0; ValidIn_SI = 0;
    HypervectorIn_DI = '0; ReadyIn_SI = 1;
    repeat (2) @(posedge Clk_CI);
    @(negedge Clk_CI);
    chk("rst_valid", ValidOut_SO, 0);
    chk("rst_done", Done_SO, 0);
    chk("rst_busy", Busy_SO, 0);
    chk("rst_count", SampleCount_DO, 0);
    chk("rst_cmd_ready", CmdReady_SO, 1);
    chk("rst_ready_out", ReadyOut_SO, 0);
    chk("rst_mode", ModeOut_SO, 0);
    chk("rst_label", LabelOut_DO, 0);
    chk("rst_hv_zero", HypervectorOut_DO == '0, 1);
    Reset_RBI = 1;

    for (int i = 0; i < 10; i++) begin
      drive_cmd(tbl[i]);
      check_vec(tbl[i]);
    end

    // Reset while streaming with a beat in the output register.
    @(negedge Clk_CI);
    CmdValid_SI = 1; CmdMode_SI = 2'd1; CmdLabel_DI = 5'd6;
    CmdLength_DI = 8'd6; ValidIn_SI = 0; ReadyIn_SI = 1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge Clk_CI);
      CmdValid_SI = 0; ValidIn_SI = 1; HypervectorIn_DI = rand_hv();
    end
    chk("rst_mid_pre_valid", ValidOut_SO, 1);
    Reset_RBI = 0;
    @(negedge Clk_CI);
    Reset_RBI = 1; ValidIn_SI = 0;
    chk("rst_mid_valid", ValidOut_SO, 0);
    chk("rst_mid_busy", Busy_SO, 0);
    chk("rst_mid_cmd_ready", CmdReady_SO, 1);
    chk("rst_mid_count", SampleCount_DO, 0);
    n = 0;
    repeat (6) begin
      @(negedge Clk_CI);
      if (ValidOut_SO || Done_SO) n++;
    end
    chk("rst_mid_no_sep", n, 0);

    // New command in the Done cycle while the separator is stalled.
    @(negedge Clk_CI);
    CmdValid_SI = 1; CmdMode_SI = 2'd1; CmdLabel_DI = 5'd2;
    CmdLength_DI = 8'd1; ReadyIn_SI = 1; ValidIn_SI = 0;
    @(negedge Clk_CI);
    CmdValid_SI = 0; ValidIn_SI = 1; HypervectorIn_DI = rand_hv();
    @(negedge Clk_CI);
    ValidIn_SI = 0; ReadyIn_SI = 0;
    @(negedge Clk_CI);
    ReadyIn_SI = 1;
    @(negedge Clk_CI);
    chk("b2b_sep_label", LabelOut_DO, SEP);
    chk("b2b_done", Done_SO, 1);
    chk("b2b_cmd_ready", CmdReady_SO, 1);
    ReadyIn_SI = 0; CmdValid_SI = 1; CmdMode_SI = 2'd0;
    CmdLabel_DI = 5'd5; CmdLength_DI = 8'd1;
    ValidIn_SI = 1; hb = rand_hv(); HypervectorIn_DI = hb;
    @(negedge Clk_CI);
    CmdValid_SI = 0;
    #2 chk("b2b_held_off", ReadyOut_SO, 0);
    chk("b2b_sep_held", LabelOut_DO, SEP);
    @(negedge Clk_CI);
    ReadyIn_SI = 1;
    #2 chk("b2b_accept", ReadyOut_SO, 1);
    @(negedge Clk_CI);
    ValidIn_SI = 0;
    chk("b2b_label", LabelOut_DO, 5);
    chk("b2b_mode", ModeOut_SO, 0);
    chk("b2b_hv", HypervectorOut_DO == hb, 1);
    chk("b2b_done2", Done_SO, 1);
    @(negedge Clk_CI);
    chk("b2b_drained", ValidOut_SO, 0);
    chk("b2b_done_pulse", Done_SO, 0);

    // Random traffic against a window-level reference model.
    begin
      bit act, stall;
      logic [1:0] cm;
      logic [4:0] cl;
      int clen, cgot;
      beat_t exp_q[$];
      int cnt_q[$];
      beat_t e, prev;
      act = 0; stall = 0; cm = 0; cl = 0; clen = 0; cgot = 0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge Clk_CI);
        if (c < 2970) begin
          CmdValid_SI  = ($urandom_range(0, 3) == 0);
          CmdMode_SI   = 2'($urandom_range(0, 3));
          CmdLabel_DI  = 5'($urandom_range(0, 30));
          CmdLength_DI = 8'($urandom_range(0, 5));
          CmdAbort_SI  = ($urandom_range(0, 15) == 0);
          ValidIn_SI   = ($urandom_range(0, 3) != 0);
          ReadyIn_SI   = ($urandom_range(0, 3) != 0);
        end else begin
          CmdValid_SI = 0; CmdAbort_SI = 0;
          ValidIn_SI = 0; ReadyIn_SI = 1;
        end
        HypervectorIn_DI = rand_hv();
        #2;
        if (stall)
          chk("rnd_stable", ModeOut_SO == prev.m && LabelOut_DO == prev.l &&
              HypervectorOut_DO == prev.hv, 1);
        if (Done_SO) begin
          chk("rnd_done_expected", cnt_q.size() != 0, 1);
          if (cnt_q.size() != 0)
            chk("rnd_count", SampleCount_DO, cnt_q.pop_front());
        end
        if (ValidOut_SO && ReadyIn_SI) begin
          chk("rnd_beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rnd_mode", ModeOut_SO, e.m);
            chk("rnd_label", LabelOut_DO, e.l);
            chk("rnd_hv", HypervectorOut_DO == e.hv, 1);
          end
        end
        if (ValidOut_SO && !ReadyIn_SI) chk("rnd_stall_rdy", ReadyOut_SO, 0);
        if (!act) chk("rnd_no_stream_rdy", ReadyOut_SO, 0);
        if (act) chk("rnd_busy_cmd_rdy", CmdReady_SO, 0);
        if (act && CmdAbort_SI) chk("rnd_abort_rdy", ReadyOut_SO, 0);
        if (act && !CmdAbort_SI && (!ValidOut_SO || ReadyIn_SI))
          chk("rnd_free_rdy", ReadyOut_SO, 1);
        if (act) begin
          if (CmdAbort_SI || (ValidIn_SI && ReadyOut_SO)) begin
            if (!CmdAbort_SI) begin
              exp_q.push_back('{cm, cl, HypervectorIn_DI});
              cgot++;
            end
            if (CmdAbort_SI || cgot == clen) begin
              if (cm == 2'd1 || cm == 2'd2) exp_q.push_back('{cm, SEP, '0});
              cnt_q.push_back(cgot);
              act = 0;
            end
          end
        end else if (CmdValid_SI && CmdReady_SO) begin
          cm = CmdMode_SI; cl = CmdLabel_DI;
          clen = int'(CmdLength_DI); cgot = 0;
          if (clen == 0) begin
            if (cm == 2'd1 || cm == 2'd2) exp_q.push_back('{cm, SEP, '0});
            cnt_q.push_back(0);
          end else begin
            act = 1;
          end
        end
        stall = ValidOut_SO && !ReadyIn_SI;
        prev = '{ModeOut_SO, LabelOut_DO, HypervectorOut_DO};
      end
      chk("rnd_beats_drained", exp_q.size(), 0);
      chk("rnd_dones_drained", cnt_q.size(), 0);
      chk("rnd_idle_end", act, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
